// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug run/halt/step controller.
//   run_state_t  : controller state (RUN, HALT, STEP)
//   halt_cause_t : 3-bit halt cause reported on o_halt_cause
//   run_mode_t   : 2-bit halt-condition select
//   seg7_encode  : hex nibble to active-low seven-segment pattern (gfedcba)
package debug_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_WB    = 3'd1,
    CAUSE_BKPT  = 3'd2,
    CAUSE_REG   = 3'd3,
    CAUSE_FORCE = 3'd4,
    CAUSE_STEP  = 3'd5
  } halt_cause_t;

  typedef enum logic [1:0] {
    MODE_FREE         = 2'd0,
    MODE_HALT_ON_WB   = 2'd1,
    MODE_HALT_ON_BKPT = 2'd2,
    MODE_HALT_ON_REG  = 2'd3
  } run_mode_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bkpt_match.sv
// PC breakpoint slot file with a single write port and a parallel compare.
//   clk, rst    : clock, synchronous active-high reset (invalidates all slots)
//   bp_wr_en    : write strobe for slot bp_idx (address bp_addr, enable bp_valid)
//   pc          : PC to compare against every valid slot
//   hit         : combinational; some valid registered slot equals pc
// A write only lands at the clock edge, so it never affects the compare of
// the cycle in which it is issued.
module bkpt_match #(
  parameter int NUM_BKPT   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bp_wr_en,
  input  logic [IDX_WIDTH-1:0]  bp_idx,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic                  bp_valid,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  hit
);

  logic [ADDR_WIDTH-1:0] slot_addr [NUM_BKPT];
  logic [NUM_BKPT-1:0]   slot_valid;

  // NOTE: only the valid bits are reset; an invalid slot's address is never
  // looked at, so the address array stays reset-free and maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
    end else if (bp_wr_en) begin
      for (int i = 0; i < NUM_BKPT; i++) begin
        if (bp_idx == IDX_WIDTH'(i)) slot_valid[i] <= bp_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bp_wr_en) begin
      for (int i = 0; i < NUM_BKPT; i++) begin
        if (bp_idx == IDX_WIDTH'(i)) slot_addr[i] <= bp_addr;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BKPT; i++) begin
      if (slot_valid[i] && (slot_addr[i] == pc)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/debug_run_ctrl.sv
// Run/halt/single-step controller for FPGA bring-up. Drives a clock enable
// for the core (the clock itself is never gated), halts on a selectable
// writeback condition, captures the last retired writeback and shows a
// selectable value on NUM_DIGITS active-low seven-segment digits.
//   clk, rst            : clock, synchronous active-high reset
//   i_mode              : 0 FREE, 1 HALT_ON_WB, 2 HALT_ON_BKPT, 3 HALT_ON_REG
//   i_wb_*              : retire event, PC, destination register, data
//   i_watch_reg         : register watched in HALT_ON_REG
//   i_bp_*              : breakpoint slot write port
//   i_resume, i_step    : single-cycle pulses
//   i_force_halt        : level halt request (acts only in RUN)
//   i_disp_sel          : 0 data, 1 PC, 2 rdest, 3 retire count
//   o_clk_en, o_halted, o_halt_cause, o_retire_cnt, o_hex : status / display
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_BKPT       = 4,
  parameter int NUM_DIGITS     = 8,
  parameter bit START_HALTED   = 1'b0,
  localparam int BP_IDX_WIDTH  = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                i_mode,
  input  logic                      i_wb_en,
  input  logic [ADDR_WIDTH-1:0]     i_wb_pc,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rdest,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_watch_reg,
  input  logic                      i_bp_wr_en,
  input  logic [BP_IDX_WIDTH-1:0]   i_bp_idx,
  input  logic [ADDR_WIDTH-1:0]     i_bp_addr,
  input  logic                      i_bp_valid,
  input  logic                      i_resume,
  input  logic                      i_step,
  input  logic                      i_force_halt,
  input  logic [1:0]                i_disp_sel,
  output logic                      o_clk_en,
  output logic                      o_halted,
  output logic [2:0]                o_halt_cause,
  output logic [31:0]               o_retire_cnt,
  output logic [7*NUM_DIGITS-1:0]   o_hex
);

  localparam int DISP_WIDTH = 4 * NUM_DIGITS;

  run_state_t  state_q, state_d;
  halt_cause_t cause_q, cause_d;
  halt_cause_t trig_cause;
  run_mode_t   mode;
  logic        valid_ev;
  logic        bp_hit;

  logic [DATA_WIDTH-1:0]     data_q;
  logic [ADDR_WIDTH-1:0]     pc_q;
  logic [REG_ADDR_WIDTH-1:0] rdest_q;
  logic [31:0]               retire_cnt_q;
  logic [DISP_WIDTH-1:0]     disp_src;

  assign mode     = run_mode_t'(i_mode);
  assign o_clk_en = (state_q != HALT);
  assign o_halted = (state_q == HALT);
  // Events arriving while the core is stalled did not really retire.
  assign valid_ev = i_wb_en && o_clk_en;

  bkpt_match #(
    .NUM_BKPT   (NUM_BKPT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (BP_IDX_WIDTH)
  ) u_bkpt_match (
    .clk      (clk),
    .rst      (rst),
    .bp_wr_en (i_bp_wr_en),
    .bp_idx   (i_bp_idx),
    .bp_addr  (i_bp_addr),
    .bp_valid (i_bp_valid),
    .pc       (i_wb_pc),
    .hit      (bp_hit)
  );

  // NOTE: every variable driven here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    trig_cause = CAUSE_NONE;
    if (valid_ev) begin
      case (mode)
        MODE_HALT_ON_WB:   trig_cause = CAUSE_WB;
        MODE_HALT_ON_BKPT: if (bp_hit) trig_cause = CAUSE_BKPT;
        MODE_HALT_ON_REG:  if (i_wb_rdest == i_watch_reg) trig_cause = CAUSE_REG;
        default:           trig_cause = CAUSE_NONE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      RUN: begin
        // A trigger outranks a simultaneous force request.
        if (trig_cause != CAUSE_NONE) begin
          state_d = HALT;
          cause_d = trig_cause;
        end else if (i_force_halt) begin
          state_d = HALT;
          cause_d = CAUSE_FORCE;
        end
      end
      HALT: begin
        // Step wins over resume when both pulse together.
        if (i_step) begin
          state_d = STEP;
        end else if (i_resume) begin
          state_d = RUN;
          cause_d = CAUSE_NONE;
        end
      end
      STEP: begin
        state_d = HALT;
        cause_d = (trig_cause != CAUSE_NONE) ? trig_cause : CAUSE_STEP;
      end
      default: begin
        state_d = HALT;
        cause_d = CAUSE_FORCE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_HALTED ? HALT : RUN;
      cause_q <= START_HALTED ? CAUSE_FORCE : CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      pc_q         <= '0;
      rdest_q      <= '0;
      retire_cnt_q <= '0;
    end else if (valid_ev) begin
      data_q       <= i_wb_data;
      pc_q         <= i_wb_pc;
      rdest_q      <= i_wb_rdest;
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign o_halt_cause = cause_q;
  assign o_retire_cnt = retire_cnt_q;

  always_comb begin
    case (i_disp_sel)
      2'd0:    disp_src = DISP_WIDTH'(data_q);
      2'd1:    disp_src = DISP_WIDTH'(pc_q);
      2'd2:    disp_src = DISP_WIDTH'(rdest_q);
      default: disp_src = DISP_WIDTH'(retire_cnt_q);
    endcase
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign o_hex[7*k +: 7] = seg7_encode(disp_src[4*k +: 4]);
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
module tb_debug_run_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int NB = 4;
  localparam int ND = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = '0;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_pc = '0;
  logic [RW-1:0] wb_rdest = '0;
  logic [DW-1:0] wb_data = '0;
  logic [RW-1:0] watch_reg = '0;
  logic          bp_wr_en = 1'b0;
  logic [1:0]    bp_idx = '0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_valid = 1'b0;
  logic          resume = 1'b0;
  logic          step = 1'b0;
  logic          force_halt = 1'b0;
  logic [1:0]    disp_sel = '0;

  logic          clk_en, halted;
  logic [2:0]    cause;
  logic [31:0]   cnt;
  logic [7*ND-1:0] hex;
  logic          h_clk_en, h_halted;
  logic [2:0]    h_cause;
  logic [31:0]   h_cnt;
  logic [7*ND-1:0] h_hex;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debug_run_ctrl #(.START_HALTED(1'b0)) dut (
    .clk(clk), .rst(rst), .i_mode(mode), .i_wb_en(wb_en), .i_wb_pc(wb_pc),
    .i_wb_rdest(wb_rdest), .i_wb_data(wb_data), .i_watch_reg(watch_reg),
    .i_bp_wr_en(bp_wr_en), .i_bp_idx(bp_idx), .i_bp_addr(bp_addr),
    .i_bp_valid(bp_valid), .i_resume(resume), .i_step(step),
    .i_force_halt(force_halt), .i_disp_sel(disp_sel), .o_clk_en(clk_en),
    .o_halted(halted), .o_halt_cause(cause), .o_retire_cnt(cnt), .o_hex(hex)
  );

  debug_run_ctrl #(.START_HALTED(1'b1)) dut_h (
    .clk(clk), .rst(rst), .i_mode(mode), .i_wb_en(wb_en), .i_wb_pc(wb_pc),
    .i_wb_rdest(wb_rdest), .i_wb_data(wb_data), .i_watch_reg(watch_reg),
    .i_bp_wr_en(bp_wr_en), .i_bp_idx(bp_idx), .i_bp_addr(bp_addr),
    .i_bp_valid(bp_valid), .i_resume(resume), .i_step(step),
    .i_force_halt(force_halt), .i_disp_sel(disp_sel), .o_clk_en(h_clk_en),
    .o_halted(h_halted), .o_halt_cause(h_cause), .o_retire_cnt(h_cnt), .o_hex(h_hex)
  );

  // Reference model of the START_HALTED=0 instance. Mode: 0 running,
  // 1 halted, 2 single-step cycle in flight.
  int          m_st = 0;
  int          m_cause = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pc = '0;
  logic [RW-1:0] m_rd = '0;
  logic [31:0] m_bpa [NB];
  bit          m_bpv [NB];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [7*ND-1:0] hex_of(input logic [31:0] v);
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = seg_of(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [7*ND-1:0] exp_hex();
    case (disp_sel)
      2'd0:    return hex_of(m_data);
      2'd1:    return hex_of(m_pc);
      2'd2:    return hex_of({27'd0, m_rd});
      default: return hex_of(m_cnt);
    endcase
  endfunction

  task automatic model_step();
    bit valid;
    int trig;
    valid = wb_en && (m_st != 1);
    trig = 0;
    if (valid) begin
      if (mode == 2'd1) trig = 1;
      if (mode == 2'd2) for (int i = 0; i < NB; i++) if (m_bpv[i] && m_bpa[i] == wb_pc) trig = 2;
      if (mode == 2'd3 && wb_rdest == watch_reg) trig = 3;
    end
    if (rst) begin
      m_st = 0; m_cause = 0; m_cnt = 0; m_data = 0; m_pc = 0; m_rd = 0;
      for (int i = 0; i < NB; i++) m_bpv[i] = 0;
      return;
    end
    if (valid) begin
      m_data = wb_data; m_pc = wb_pc; m_rd = wb_rdest; m_cnt = m_cnt + 1;
    end
    if (bp_wr_en) begin
      m_bpa[bp_idx] = bp_addr; m_bpv[bp_idx] = bp_valid;
    end
    if (m_st == 0) begin
      if (trig != 0) begin m_st = 1; m_cause = trig; end
      else if (force_halt) begin m_st = 1; m_cause = 4; end
    end else if (m_st == 1) begin
      if (step) m_st = 2;
      else if (resume) begin m_st = 0; m_cause = 0; end
    end else begin
      m_st = 1;
      m_cause = (trig != 0) ? trig : 5;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL reset_clk_en got=%0b exp=1", clk_en); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (cause !== 3'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", cause); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (hex !== {ND{7'h40}}) begin failures++; $display("FAIL reset_hex got=%h exp=%h", hex, {ND{7'h40}}); end
  endtask

  task automatic test_wb_halt();
    mode = 2'd1; disp_sel = 2'd0;
    wb_en = 1'b1; wb_data = 32'hDEADBEEF; wb_pc = 32'h40; wb_rdest = 5'd7;
    tick();
    checks++; if (halted !== 1'b1 || clk_en !== 1'b0) begin failures++; $display("FAIL wb_halt got halted=%0b clk_en=%0b exp 1/0", halted, clk_en); end
    checks++; if (cause !== 3'd1) begin failures++; $display("FAIL wb_cause got=%0d exp=1", cause); end
    wb_data = 32'h1;
    tick();
    wb_en = 1'b0;
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL wb_ignored_cnt got=%0d exp=1", cnt); end
    checks++; if (hex !== hex_of(32'hDEADBEEF)) begin failures++; $display("FAIL wb_hex got=%h exp=%h", hex, hex_of(32'hDEADBEEF)); end
    resume = 1'b1; tick(); resume = 1'b0;
    checks++; if (halted !== 1'b0 || cause !== 3'd0) begin failures++; $display("FAIL wb_resume got halted=%0b cause=%0d exp 0/0", halted, cause); end
  endtask

  task automatic test_bkpt();
    mode = 2'd2;
    bp_wr_en = 1'b1; bp_idx = 2'd2; bp_addr = 32'h100; bp_valid = 1'b1;
    tick(); bp_wr_en = 1'b0;
    wb_en = 1'b1; wb_pc = 32'hFC; tick();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bkpt_nohit got=%0b exp=0", halted); end
    wb_pc = 32'h100; tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd2) begin failures++; $display("FAIL bkpt_hit got halted=%0b cause=%0d exp 1/2", halted, cause); end
    disp_sel = 2'd1; #1;
    checks++; if (hex !== hex_of(32'h100)) begin failures++; $display("FAIL bkpt_hex got=%h exp=%h", hex, hex_of(32'h100)); end
    resume = 1'b1; tick(); resume = 1'b0;
    // Slot write in the same cycle as a matching event must not trigger it.
    wb_en = 1'b1; wb_pc = 32'h300;
    bp_wr_en = 1'b1; bp_idx = 2'd0; bp_addr = 32'h300; bp_valid = 1'b1;
    tick(); bp_wr_en = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bkpt_same_cycle got=%0b exp=0", halted); end
    tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd2) begin failures++; $display("FAIL bkpt_next got halted=%0b cause=%0d exp 1/2", halted, cause); end
    checks++; if (cnt !== m_cnt) begin failures++; $display("FAIL bkpt_cnt got=%0d exp=%0d", cnt, m_cnt); end
  endtask

  task automatic test_step();
    logic [31:0] base;
    base = m_cnt;
    mode = 2'd0; wb_pc = 32'h0;
    step = 1'b1; resume = 1'b1; wb_en = 1'b1;
    tick(); step = 1'b0; resume = 1'b0;
    checks++; if (clk_en !== 1'b1 || cnt !== base) begin failures++; $display("FAIL step_enter got clk_en=%0b cnt=%0d exp 1/%0d", clk_en, cnt, base); end
    tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd5 || cnt !== base + 1) begin failures++; $display("FAIL step_ev got halted=%0b cause=%0d cnt=%0d exp 1/5/%0d", halted, cause, cnt, base + 1); end
    step = 1'b1; tick(); step = 1'b0;
    tick();
    checks++; if (halted !== 1'b1 || cause !== 3'd5 || cnt !== base + 1) begin failures++; $display("FAIL step_idle got halted=%0b cause=%0d cnt=%0d exp 1/5/%0d", halted, cause, cnt, base + 1); end
    step = 1'b1; tick(); step = 1'b0;
    mode = 2'd1; wb_en = 1'b1; tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd1 || cnt !== base + 2) begin failures++; $display("FAIL step_trig got halted=%0b cause=%0d cnt=%0d exp 1/1/%0d", halted, cause, cnt, base + 2); end
  endtask

  task automatic test_reg();
    resume = 1'b1; tick(); resume = 1'b0;
    mode = 2'd3; watch_reg = 5'd5; wb_en = 1'b1; wb_rdest = 5'd3; tick();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reg_x3 got=%0b exp=0", halted); end
    wb_rdest = 5'd5; tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd3) begin failures++; $display("FAIL reg_x5 got halted=%0b cause=%0d exp 1/3", halted, cause); end
    disp_sel = 2'd2; #1;
    checks++; if (hex !== hex_of(32'h5)) begin failures++; $display("FAIL reg_hex got=%h exp=%h", hex, hex_of(32'h5)); end
  endtask

  task automatic test_force();
    mode = 2'd1;
    resume = 1'b1; tick(); resume = 1'b0;
    force_halt = 1'b1; wb_en = 1'b1; tick(); wb_en = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 3'd1) begin failures++; $display("FAIL force_prio got halted=%0b cause=%0d exp 1/1", halted, cause); end
    tick();
    checks++; if (halted !== 1'b1 || cause !== 3'd1) begin failures++; $display("FAIL force_held got halted=%0b cause=%0d exp 1/1", halted, cause); end
    resume = 1'b1; tick(); resume = 1'b0;
    checks++; if (clk_en !== 1'b1 || cause !== 3'd0) begin failures++; $display("FAIL force_resume got clk_en=%0b cause=%0d exp 1/0", clk_en, cause); end
    tick();
    checks++; if (halted !== 1'b1 || cause !== 3'd4) begin failures++; $display("FAIL force_rehalt got halted=%0b cause=%0d exp 1/4", halted, cause); end
    force_halt = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      mode       = 2'($urandom_range(0, 3));
      wb_en      = 1'($urandom);
      wb_pc      = 32'h100 + 32'(4 * $urandom_range(0, 3));
      wb_rdest   = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      watch_reg  = 5'($urandom_range(0, 7));
      bp_wr_en   = ($urandom_range(0, 7) == 0);
      bp_idx     = 2'($urandom);
      bp_addr    = 32'h100 + 32'(4 * $urandom_range(0, 3));
      bp_valid   = 1'($urandom);
      resume     = ($urandom_range(0, 3) == 0);
      step       = ($urandom_range(0, 5) == 0);
      force_halt = ($urandom_range(0, 15) == 0);
      disp_sel   = 2'($urandom);
      tick();
      checks++; if (clk_en !== (m_st != 1)) begin failures++; $display("FAIL rnd_clk_en cyc=%0d got=%0b exp=%0b", c, clk_en, m_st != 1); end
      checks++; if (halted !== (m_st == 1)) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", c, halted, m_st == 1); end
      checks++; if (cause !== 3'(m_cause)) begin failures++; $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", c, cause, m_cause); end
      checks++; if (cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, cnt, m_cnt); end
      checks++; if (hex !== exp_hex()) begin failures++; $display("FAIL rnd_hex cyc=%0d got=%h exp=%h", c, hex, exp_hex()); end
    end
    rst = 1'b0; wb_en = 1'b0; bp_wr_en = 1'b0; resume = 1'b0; step = 1'b0;
    force_halt = 1'b0; disp_sel = 2'd0;
  endtask

  task automatic test_start_halted();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (h_halted !== 1'b1 || h_clk_en !== 1'b0 || h_cause !== 3'd4) begin failures++; $display("FAIL sh_reset got halted=%0b clk_en=%0b cause=%0d exp 1/0/4", h_halted, h_clk_en, h_cause); end
    checks++; if (h_hex !== {ND{7'h40}} || h_cnt !== 32'd0) begin failures++; $display("FAIL sh_reset_disp got hex=%h cnt=%0d exp %h/0", h_hex, h_cnt, {ND{7'h40}}); end
    mode = 2'd2;
    bp_wr_en = 1'b1; bp_idx = 2'd1; bp_addr = 32'h200; bp_valid = 1'b1;
    tick(); bp_wr_en = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    checks++; if (h_clk_en !== 1'b1) begin failures++; $display("FAIL sh_step got clk_en=%0b exp=1", h_clk_en); end
    wb_en = 1'b1; wb_pc = 32'h200; rst = 1'b1;
    tick(); rst = 1'b0; wb_en = 1'b0;
    checks++; if (h_halted !== 1'b1 || h_cause !== 3'd4 || h_cnt !== 32'd0) begin failures++; $display("FAIL sh_rst_step got halted=%0b cause=%0d cnt=%0d exp 1/4/0", h_halted, h_cause, h_cnt); end
    step = 1'b1; tick(); step = 1'b0;
    wb_en = 1'b1; wb_pc = 32'h200; tick(); wb_en = 1'b0;
    checks++; if (h_halted !== 1'b1 || h_cause !== 3'd5 || h_cnt !== 32'd1) begin failures++; $display("FAIL sh_slots_cleared got halted=%0b cause=%0d cnt=%0d exp 1/5/1", h_halted, h_cause, h_cnt); end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin m_bpv[i] = 0; m_bpa[i] = '0; end
    test_reset();
    test_wb_halt();
    test_bkpt();
    test_step();
    test_reg();
    test_force();
    test_random();
    test_start_halted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
